multdiv_unit: RTL

Multi-cycle signed 32-bit multiplier/divider in the execute stage, alongside the single-cycle ALU (bitwise AND/OR, add/sub, shift). It takes the same D/X operands as the ALU. Its result feeds the same X/M result mux as the ALU result. The pipeline stalls while `busy` is high and captures `data_result` on the cycle `data_resultRDY` pulses. Multiply uses radix-2 shift-add on magnitudes. Divide uses restoring shift-subtract on magnitudes. Signs are fixed up at the end.

---
 rtl/multdiv_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_unit
//  Purpose  : Multi-cycle signed multiplier / divider for the execute stage.
//             Multiply is radix-2 shift-add on operand magnitudes, divide is
//             restoring shift-subtract on magnitudes; the sign is applied in
//             the final (DONE) cycle. One iteration per clock, WIDTH
//             iterations, result registered WIDTH+1 edges after the start.
//  Ports    : clock          - rising-edge clock
//             reset_n        - asynchronous active-low reset
//             data_operandA  - multiplicand / dividend (two's complement)
//             data_operandB  - multiplier / divisor (two's complement)
//             ctrl_MULT      - start-multiply pulse
//             ctrl_DIV       - start-divide pulse
//             data_result    - low WIDTH bits of product, or quotient
//             data_exception - multiply overflow, divide-by-zero or
//                              most-negative / -1
//             data_resultRDY - one-cycle completion pulse
//             busy           - operation in flight (through the RDY cycle)
//  Revision : 1.0 - initial release
// ============================================================================
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [5:0] c_cnt_last = 6'(WIDTH - 1);

  state_e             state_q,  state_d;
  logic [5:0]         cnt_q,    cnt_d;
  logic               is_div_q, is_div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0]   mag_q,    mag_d;
  // Multiply: {accumulator high half, multiplier shifting out of the bottom}.
  // Divide:   {remainder, quotient shifting in at the bottom}.
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q,    exc_d;
  logic               rdy_q,    rdy_d;

  logic               w_start;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_shl;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic               w_neg;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH:0]     w_prod_top;
  logic               w_mul_exc;
  logic [WIDTH-1:0]   w_quo;
  logic               w_div_exc;

  // Exactly one start line high; both high together is ignored.
  assign w_start = ctrl_MULT ^ ctrl_DIV;

  // Negating the most-negative value yields the same bit pattern, which read
  // as unsigned is its correct magnitude.
  assign w_mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // Shift-add step: the carry out of the add becomes the new top bit.
  assign w_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_q};
  assign w_mul_next = acc_q[0] ? {w_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

  // Restoring step: the remainder stays below the divisor magnitude, so the
  // shifted remainder always fits in WIDTH bits; the extra bit of the trial
  // difference is the borrow.
  assign w_shl      = {acc_q[2*WIDTH-2:0], 1'b0};
  assign w_diff     = {1'b0, w_shl[2*WIDTH-1:WIDTH]} - {1'b0, mag_q};
  assign w_div_next = w_diff[WIDTH] ? w_shl
                                    : {w_diff[WIDTH-1:0], w_shl[WIDTH-1:1], 1'b1};

  // Sign correction and exception detection, used in the DONE cycle.
  assign w_neg      = sign_a_q ^ sign_b_q;
  assign w_prod_s   = w_neg ? -acc_q : acc_q;
  assign w_prod_top = w_prod_s[2*WIDTH-1:WIDTH-1];
  assign w_mul_exc  = ~((&w_prod_top) | ~(|w_prod_top));
  assign w_quo      = acc_q[WIDTH-1:0];
  // A positive quotient with the top bit set can only be min / -1.
  assign w_div_exc  = (mag_q == '0) | (~w_neg & w_quo[WIDTH-1]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    mag_d    = mag_q;
    acc_d    = acc_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    if (w_start) begin
      // A start in any state (including DONE) restarts from scratch and
      // suppresses completion of whatever was in flight.
      state_d  = S_RUN;
      cnt_d    = 6'd0;
      is_div_d = ctrl_DIV;
      sign_a_d = data_operandA[WIDTH-1];
      sign_b_d = data_operandB[WIDTH-1];
      mag_d    = ctrl_DIV ? w_mag_b : w_mag_a;
      acc_d    = {{WIDTH{1'b0}}, (ctrl_DIV ? w_mag_a : w_mag_b)};
    end else begin
      case (state_q)
        S_RUN: begin
          acc_d = is_div_q ? w_div_next : w_mul_next;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == c_cnt_last) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (is_div_q) begin
            exc_d    = w_div_exc;
            result_d = w_div_exc ? '0 : (w_neg ? -w_quo : w_quo);
          end else begin
            exc_d    = w_mul_exc;
            result_d = w_prod_s[WIDTH-1:0];
          end
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  // Busy covers the RDY cycle so the pipeline stalls until it captures.
  assign busy           = (state_q != S_IDLE) | rdy_q;

endmodule
`default_nettype wire
